// File: rtl/rob_ctrl_if.sv
// Reorder-buffer control bundle: rename allocation, FU completion strobes,
// retirement and occupancy status. Master = pipeline side, slave = rob_ctrl.
interface rob_ctrl_if #(
  parameter int IDX_W  = 5,
  parameter int PREG_W = 6
);
  logic              alloc_req_1;
  logic              alloc_req_2;
  logic [PREG_W-1:0] alloc_old_preg_1;
  logic [PREG_W-1:0] alloc_old_preg_2;
  logic              alloc_gnt_1;
  logic              alloc_gnt_2;
  logic [IDX_W-1:0]  alloc_idx_1;
  logic [IDX_W-1:0]  alloc_idx_2;

  logic              cmpl_vld_1;
  logic              cmpl_vld_2;
  logic              cmpl_vld_3;
  logic [IDX_W-1:0]  cmpl_idx_1;
  logic [IDX_W-1:0]  cmpl_idx_2;
  logic [IDX_W-1:0]  cmpl_idx_3;

  logic              retire_vld_1;
  logic              retire_vld_2;
  logic [PREG_W-1:0] retire_preg_1;
  logic [PREG_W-1:0] retire_preg_2;

  logic              rob_full;
  logic              rob_empty;
  logic [IDX_W:0]    rob_count;

  modport master (
    output alloc_req_1, alloc_req_2, alloc_old_preg_1, alloc_old_preg_2,
    input  alloc_gnt_1, alloc_gnt_2, alloc_idx_1, alloc_idx_2,
    output cmpl_vld_1, cmpl_vld_2, cmpl_vld_3,
    output cmpl_idx_1, cmpl_idx_2, cmpl_idx_3,
    input  retire_vld_1, retire_vld_2, retire_preg_1, retire_preg_2,
    input  rob_full, rob_empty, rob_count
  );

  modport slave (
    input  alloc_req_1, alloc_req_2, alloc_old_preg_1, alloc_old_preg_2,
    output alloc_gnt_1, alloc_gnt_2, alloc_idx_1, alloc_idx_2,
    input  cmpl_vld_1, cmpl_vld_2, cmpl_vld_3,
    input  cmpl_idx_1, cmpl_idx_2, cmpl_idx_3,
    output retire_vld_1, retire_vld_2, retire_preg_1, retire_preg_2,
    output rob_full, rob_empty, rob_count
  );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer allocation/completion/retirement controller (2-wide alloc and retire,
// 3 completion ports). Define ROB_CTRL_FLUSH_EN to add the flush input.
module rob_ctrl #(
  parameter int ROB_DEPTH = 32,
  parameter int IDX_W     = 5,
  parameter int PREG_W    = 6
) (
  input logic clk,
  input logic rst_n,
`ifdef ROB_CTRL_FLUSH_EN
  input logic flush,
`endif
  rob_ctrl_if.slave bus
);

  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(ROB_DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_TWO   = (IDX_W+1)'(2);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic [ROB_DEPTH-1:0] in_use_q, in_use_d;
  logic [ROB_DEPTH-1:0] cmpl_q, cmpl_d;
  logic [PREG_W-1:0]    old_preg_q [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [IDX_W-1:0]     head_nx_s, tail_nx_s;
  logic [IDX_W:0]       count_q, count_d, free_s;
  logic                 gnt_1_s, gnt_2_s, ret_1_s, ret_2_s, flush_s;
  logic                 retire_vld_1_q, retire_vld_2_q;
  logic [PREG_W-1:0]    retire_preg_1_q, retire_preg_2_q;

`ifdef ROB_CTRL_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign head_nx_s = head_q + IDX_ONE;
  assign tail_nx_s = tail_q + IDX_ONE;

  // Grants look only at the registered count, so slots freed this cycle wait one cycle.
  always_comb begin
    free_s  = DEPTH_CNT - count_q;
    gnt_1_s = 1'b0;
    gnt_2_s = 1'b0;
    if (rst_n && !flush_s && bus.alloc_req_1) begin
      gnt_1_s = (free_s >= CNT_ONE);
      gnt_2_s = bus.alloc_req_2 && (free_s >= CNT_TWO);
    end else begin
      gnt_1_s = 1'b0;
      gnt_2_s = 1'b0;
    end
  end

  // In-order retirement from pre-edge head state.
  always_comb begin
    ret_1_s = in_use_q[head_q] && cmpl_q[head_q];
    ret_2_s = ret_1_s && in_use_q[head_nx_s] && cmpl_q[head_nx_s];
  end

  // Entry flag update: completions, then retire clears, then allocation writes win.
  always_comb begin
    in_use_d = in_use_q;
    cmpl_d   = cmpl_q;

    cmpl_d[bus.cmpl_idx_1] = cmpl_d[bus.cmpl_idx_1] | (bus.cmpl_vld_1 & in_use_q[bus.cmpl_idx_1]);
    cmpl_d[bus.cmpl_idx_2] = cmpl_d[bus.cmpl_idx_2] | (bus.cmpl_vld_2 & in_use_q[bus.cmpl_idx_2]);
    cmpl_d[bus.cmpl_idx_3] = cmpl_d[bus.cmpl_idx_3] | (bus.cmpl_vld_3 & in_use_q[bus.cmpl_idx_3]);

    in_use_d[head_q]    = in_use_d[head_q]    & ~ret_1_s;
    cmpl_d[head_q]      = cmpl_d[head_q]      & ~ret_1_s;
    in_use_d[head_nx_s] = in_use_d[head_nx_s] & ~ret_2_s;
    cmpl_d[head_nx_s]   = cmpl_d[head_nx_s]   & ~ret_2_s;

    in_use_d[tail_q]    = in_use_d[tail_q]    | gnt_1_s;
    cmpl_d[tail_q]      = cmpl_d[tail_q]      & ~gnt_1_s;
    in_use_d[tail_nx_s] = in_use_d[tail_nx_s] | gnt_2_s;
    cmpl_d[tail_nx_s]   = cmpl_d[tail_nx_s]   & ~gnt_2_s;

    tail_d  = tail_q + IDX_W'(gnt_1_s) + IDX_W'(gnt_2_s);
    head_d  = head_q + IDX_W'(ret_1_s) + IDX_W'(ret_2_s);
    count_d = count_q + (IDX_W+1)'(gnt_1_s) + (IDX_W+1)'(gnt_2_s)
                      - (IDX_W+1)'(ret_1_s) - (IDX_W+1)'(ret_2_s);
  end

  // State and registered retire outputs; reset outranks flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_use_q        <= '0;
      cmpl_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      retire_vld_1_q  <= 1'b0;
      retire_vld_2_q  <= 1'b0;
      retire_preg_1_q <= '0;
      retire_preg_2_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        old_preg_q[i] <= '0;
      end
    end else if (flush_s) begin
      in_use_q       <= '0;
      cmpl_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_vld_1_q <= 1'b0;
      retire_vld_2_q <= 1'b0;
    end else begin
      in_use_q       <= in_use_d;
      cmpl_q         <= cmpl_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_vld_1_q <= ret_1_s;
      retire_vld_2_q <= ret_2_s;
      if (gnt_1_s) old_preg_q[tail_q] <= bus.alloc_old_preg_1;
      if (gnt_2_s) old_preg_q[tail_nx_s] <= bus.alloc_old_preg_2;
      if (ret_1_s) retire_preg_1_q <= old_preg_q[head_q];
      if (ret_2_s) retire_preg_2_q <= old_preg_q[head_nx_s];
    end
  end

  assign bus.alloc_gnt_1   = gnt_1_s;
  assign bus.alloc_gnt_2   = gnt_2_s;
  assign bus.alloc_idx_1   = tail_q;
  assign bus.alloc_idx_2   = tail_nx_s;
  assign bus.retire_vld_1  = retire_vld_1_q;
  assign bus.retire_vld_2  = retire_vld_2_q;
  assign bus.retire_preg_1 = retire_preg_1_q;
  assign bus.retire_preg_2 = retire_preg_2_q;
  assign bus.rob_full      = (count_q == DEPTH_CNT);
  assign bus.rob_empty     = (count_q == {(IDX_W+1){1'b0}});
  assign bus.rob_count     = count_q;

endmodule
